// File: rtl/fpu_pkg.sv
// Shared floating-point definitions used by the divider, its result queue and
// the other arithmetic units.
package fpu_pkg;

  localparam int DEF_NEXP = 8;
  localparam int DEF_NSIG = 23;

  // Classification flag bit positions shared across the arithmetic units.
  localparam int SNAN      = 0;
  localparam int QNAN      = 1;
  localparam int INFINITY  = 2;
  localparam int ZERO      = 3;
  localparam int SUBNORMAL = 4;
  localparam int NORMAL    = 5;
  localparam int LAST_FLAG = 6;

  function automatic logic fp_is_nan(input logic [DEF_NEXP+DEF_NSIG:0] x);
    return (&x[DEF_NEXP+DEF_NSIG-1:DEF_NSIG]) && (|x[DEF_NSIG-1:0]);
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic synchronous FIFO: storage, wrapping pointers and an occupancy count.
// Full/empty come from the count, so the pointers can simply wrap.
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately unreset; count gates its validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

endmodule

// File: rtl/fpu_div_result_queue.sv
// Result stage behind the combinational divider: buffers quotients with their
// exception bits, tags NaNs at push, and keeps sticky flags plus an event count.
module fpu_div_result_queue
  import fpu_pkg::*;
#(
  parameter int NEXP  = DEF_NEXP,
  parameter int NSIG  = DEF_NSIG,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NEXP+NSIG:0]        in_q,
  input  logic                      in_overflow,
  input  logic                      in_underflow,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NEXP+NSIG:0]        out_q,
  output logic                      out_overflow,
  output logic                      out_underflow,
  output logic                      out_invalid,
  output logic [$clog2(DEPTH):0]    count,
  input  logic                      sticky_clr,
  output logic                      sticky_ovf,
  output logic                      sticky_unf,
  output logic                      sticky_inv,
  output logic [CNTW-1:0]           exc_count
);

  localparam int QW = NEXP + NSIG + 1;
  localparam int EW = QW + 3;

  logic          in_nan;
  logic          push;
  logic          has_exc;
  logic          full, empty;
  logic [EW-1:0] wr_entry, rd_entry;

  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            inv_q, inv_d;
  logic [CNTW-1:0] exc_q, exc_d;

  assign in_nan   = (&in_q[NEXP+NSIG-1:NSIG]) && (|in_q[NSIG-1:0]);
  assign wr_entry = {in_q, in_overflow, in_underflow, in_nan};
  assign in_ready = !full;
  assign out_valid = !empty;
  assign push     = in_valid && in_ready;
  assign has_exc  = in_overflow || in_underflow || in_nan;

  fpu_sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (in_valid),
    .pop_i     (out_ready),
    .wr_data_i (wr_entry),
    .rd_data_o (rd_entry),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty)
  );

  assign {out_q, out_overflow, out_underflow, out_invalid} = rd_entry;

  // A push in the same cycle as a clear wins: flags take the pushed bits.
  always_comb begin
    ovf_d = ovf_q;
    unf_d = unf_q;
    inv_d = inv_q;
    exc_d = exc_q;
    if (push) begin
      ovf_d = in_overflow  || (ovf_q && !sticky_clr);
      unf_d = in_underflow || (unf_q && !sticky_clr);
      inv_d = in_nan       || (inv_q && !sticky_clr);
    end else if (sticky_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
      inv_d = 1'b0;
    end
    if (push && has_exc) begin
      if (sticky_clr)     exc_d = CNTW'(1);
      else if (exc_q != '1) exc_d = exc_q + 1'b1;
    end else if (sticky_clr) begin
      exc_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      inv_q <= 1'b0;
      exc_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      inv_q <= inv_d;
      exc_q <= exc_d;
    end
  end

  assign sticky_ovf = ovf_q;
  assign sticky_unf = unf_q;
  assign sticky_inv = inv_q;
  assign exc_count  = exc_q;

endmodule

// File: tb/tb_fpu_div_result_queue.sv
// Randomized and directed bench for the divider result queue with a
// queue-based reference model and a negedge scoreboard.
module tb_fpu_div_result_queue;

  localparam int NEXP  = 8;
  localparam int NSIG  = 23;
  localparam int DEPTH = 4;
  localparam int CNTW  = 4;
  localparam int QW    = NEXP + NSIG + 1;
  localparam int W     = QW + 3;
  localparam int SAT   = (1 << CNTW) - 1;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [QW-1:0]          in_q = '0;
  logic                   in_overflow = 1'b0;
  logic                   in_underflow = 1'b0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [QW-1:0]          out_q;
  logic                   out_overflow;
  logic                   out_underflow;
  logic                   out_invalid;
  logic [$clog2(DEPTH):0] count;
  logic                   sticky_clr = 1'b0;
  logic                   sticky_ovf, sticky_unf, sticky_inv;
  logic [CNTW-1:0]        exc_count;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic         m_ovf = 1'b0, m_unf = 1'b0, m_inv = 1'b0;
  int           m_exc = 0;

  fpu_div_result_queue #(
    .NEXP (NEXP), .NSIG (NSIG), .DEPTH (DEPTH), .CNTW (CNTW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_q          (in_q),
    .in_overflow   (in_overflow),
    .in_underflow  (in_underflow),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_q         (out_q),
    .out_overflow  (out_overflow),
    .out_underflow (out_underflow),
    .out_invalid   (out_invalid),
    .count         (count),
    .sticky_clr    (sticky_clr),
    .sticky_ovf    (sticky_ovf),
    .sticky_unf    (sticky_unf),
    .sticky_inv    (sticky_inv),
    .exc_count     (exc_count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_nan(input logic [QW-1:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // ---------------- scoreboard / reference model ----------------
  always @(negedge clk) begin
    logic do_push, do_pop, n;
    if (!rst_n) begin
      exp_q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_inv = 1'b0; m_exc = 0;
    end else begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("sticky", 64'({sticky_ovf, sticky_unf, sticky_inv}), 64'({m_ovf, m_unf, m_inv}));
      check("exc_count", 64'(exc_count), 64'(m_exc));
      do_pop  = (exp_q.size() != 0) && out_ready;
      do_push = in_valid && (exp_q.size() < DEPTH);
      if (do_pop) begin
        check("head", 64'({out_q, out_overflow, out_underflow, out_invalid}), 64'(exp_q[0]));
        void'(exp_q.pop_front());
      end
      if (do_push) begin
        n = is_nan(in_q);
        exp_q.push_back({in_q, in_overflow, in_underflow, n});
        m_ovf = in_overflow  | (m_ovf & ~sticky_clr);
        m_unf = in_underflow | (m_unf & ~sticky_clr);
        m_inv = n            | (m_inv & ~sticky_clr);
        if (in_overflow || in_underflow || n)
          m_exc = sticky_clr ? 1 : ((m_exc < SAT) ? m_exc + 1 : SAT);
        else if (sticky_clr)
          m_exc = 0;
      end else if (sticky_clr) begin
        m_ovf = 1'b0; m_unf = 1'b0; m_inv = 1'b0; m_exc = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [31:0] q, input logic ovf, input logic unf, input logic clr);
    int waited;
    @(posedge clk) #1;
    in_valid = 1'b1; in_q = q; in_overflow = ovf; in_underflow = unf; sticky_clr = clr;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("push_timeout", 64'(waited < 200), 64'd1);
    @(posedge clk) #1;
    in_valid = 1'b0; sticky_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_q();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 3))
      0:       e = 8'hFF;
      1:       e = 8'h00;
      default: e = 8'($urandom_range(1, 254));
    endcase
    f = ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom);
    return {1'($urandom_range(0, 1)), e, f};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic stall;
    #1 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    // single pass-through result
    out_ready = 1'b1;
    push(32'h3F800000, 1'b0, 1'b0, 1'b0);
    idle(3);

    // fill, hold a fifth, release with one pop, crossing pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h40000000 + 32'(i), 1'b0, 1'b0, 1'b0);
    fork
      push(32'h40A00000, 1'b0, 1'b0, 1'b0);
      begin
        idle(3);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
      end
    join
    idle(2);
    out_ready = 1'b1;
    idle(6);

    // infinity with overflow, then a quiet NaN
    push(32'h7F800000, 1'b1, 1'b0, 1'b0);
    push(32'h7FC00000, 1'b0, 1'b0, 1'b0);
    idle(3);

    // clear coinciding with an underflow push
    push(32'h00000001, 1'b0, 1'b1, 1'b1);
    idle(3);

    // saturate the event counter while draining
    for (int i = 0; i < 20; i++) push(32'h7F800000, 1'b1, 1'b0, 1'b0);
    idle(3);

    // randomized traffic with a stable-while-stalled producer
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      stall = in_valid && !in_ready;
      @(posedge clk) #1;
      if (!stall) begin
        in_valid     = ($urandom_range(0, 1) == 1);
        in_q         = rand_q();
        in_overflow  = ($urandom_range(0, 5) == 0);
        in_underflow = ($urandom_range(0, 5) == 0);
      end
      out_ready  = ($urandom_range(0, 3) != 0);
      sticky_clr = ($urandom_range(0, 15) == 0);
    end
    in_valid = 1'b0; sticky_clr = 1'b0;
    out_ready = 1'b1;
    idle(8);

    // asynchronous reset with three entries buffered
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h3F000000 + 32'(i), 1'b1, 1'b0, 1'b0);
    @(posedge clk) #3;
    rst_n = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sticky", 64'({sticky_ovf, sticky_unf, sticky_inv, exc_count}), 64'd0);
    @(posedge clk) #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(32'h3F800000, 1'b0, 1'b0, 1'b0);
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
